// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution path: funct3 codes, the registered
// result record and the sequential PC step. Width follows `BRANCH_XLEN (default 32).
`ifndef BRANCH_XLEN
`define BRANCH_XLEN 32
`endif

package branch_pkg;

   localparam int BR_XLEN = `BRANCH_XLEN;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam int PC_STEP = 4;

   typedef struct packed {
      logic               taken;
      logic [BR_XLEN-1:0] target;
      logic [BR_XLEN-1:0] redirect_pc;
      logic               mispredict;
      logic               illegal;
   } branch_result_t;

   // The two funct3 codes that the base ISA leaves unassigned for branches.
   function automatic logic f3_is_illegal(input logic [2:0] func);
      return (func == 3'b010) || (func == 3'b011);
   endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator: one equality, one signed and one
// unsigned less-than; GE/GEU are the complements. Shared with the fetch predictor check.
module branch_cond_eval
   import branch_pkg::*;
#(
   parameter int XLEN = BR_XLEN
) (
   input  logic [2:0]      func,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            taken,
   output logic            illegal
);

   logic eq;
   logic lt;
   logic ltu;

   assign eq  = (a == b);
   assign lt  = ($signed(a) < $signed(b));
   assign ltu = (a < b);

   always_comb begin
      taken   = 1'b0;
      illegal = f3_is_illegal(func);
      case (func)
         F3_BEQ:  taken = eq;
         F3_BNE:  taken = !eq;
         F3_BLT:  taken = lt;
         F3_BGE:  taken = !lt;
         F3_BLTU: taken = ltu;
         F3_BGEU: taken = !ltu;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch resolution stage with a single valid/ready output register.
// Optional saturating statistics counters are enabled by BRANCH_RESOLVE_STATS_EN.
module branch_resolve_unit
   import branch_pkg::*;
#(
   parameter int XLEN = BR_XLEN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      in_func,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_imm,
   input  logic            in_pred_taken,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_taken,
   output logic [XLEN-1:0] out_target,
   output logic            out_mispredict,
   output logic [XLEN-1:0] out_redirect_pc,
   output logic            out_illegal
`ifdef BRANCH_RESOLVE_STATS_EN
   ,
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_mispredicts
`endif
);

   logic            cond_taken;
   logic            cond_illegal;
   logic [XLEN-1:0] target_sum;
   logic [XLEN-1:0] seq_pc;
   logic            accept;
   logic            valid_q;
   branch_result_t  next_res;
   branch_result_t  res_q;

   branch_cond_eval #(
      .XLEN (XLEN)
   ) u_cond (
      .func    (in_func),
      .a       (in_a),
      .b       (in_b),
      .taken   (cond_taken),
      .illegal (cond_illegal)
   );

   // Both adders wrap silently at 2^XLEN.
   assign target_sum = in_pc + in_imm;
   assign seq_pc     = in_pc + XLEN'(PC_STEP);

   always_comb begin
      next_res.taken       = cond_taken;
      next_res.target      = target_sum;
      next_res.redirect_pc = cond_taken ? target_sum : seq_pc;
      next_res.mispredict  = cond_taken != in_pred_taken;
      next_res.illegal     = cond_illegal;
   end

   assign in_ready = !flush && (!valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   // Flush beats accept; with no accept, a consumed result simply empties the stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         res_q   <= '0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (accept) begin
         valid_q <= 1'b1;
         res_q   <= next_res;
      end else if (out_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign out_valid       = valid_q;
   assign out_taken       = res_q.taken;
   assign out_target      = res_q.target;
   assign out_redirect_pc = res_q.redirect_pc;
   assign out_mispredict  = res_q.mispredict;
   assign out_illegal     = res_q.illegal;

`ifdef BRANCH_RESOLVE_STATS_EN
   logic consume;

   assign consume = valid_q && out_ready && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else if (consume && !res_q.illegal) begin
         if (stat_branches != '1) begin
            stat_branches <= stat_branches + 32'd1;
         end
         if (res_q.mispredict && (stat_mispredicts != '1)) begin
            stat_mispredicts <= stat_mispredicts + 32'd1;
         end
      end
   end
`else
   // Statistics build option disabled: no counters.
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed vector table, handshake corner
// sequences and a randomized run against an arithmetic reference model.
module tb_branch_resolve_unit;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [2:0]      in_func = 3'b000;
   logic [XLEN-1:0] in_a = '0;
   logic [XLEN-1:0] in_b = '0;
   logic [XLEN-1:0] in_pc = '0;
   logic [XLEN-1:0] in_imm = '0;
   logic            in_pred_taken = 1'b0;
   logic            flush = 1'b0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic            out_taken;
   logic [XLEN-1:0] out_target;
   logic            out_mispredict;
   logic [XLEN-1:0] out_redirect_pc;
   logic            out_illegal;
`ifdef BRANCH_RESOLVE_STATS_EN
   logic [31:0]     stat_branches;
   logic [31:0]     stat_mispredicts;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic        taken;
      logic [31:0] target;
      logic [31:0] redirect;
      logic        mis;
      logic        ill;
   } exp_t;

   typedef struct {
      logic [2:0]  func;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] pc;
      logic [31:0] imm;
      logic        pred;
      exp_t        exp;
   } vec_t;

   vec_t vecs[10];
   exp_t q[$];
   exp_t e;

   branch_resolve_unit #(
      .XLEN (XLEN)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_func         (in_func),
      .in_a            (in_a),
      .in_b            (in_b),
      .in_pc           (in_pc),
      .in_imm          (in_imm),
      .in_pred_taken   (in_pred_taken),
      .flush           (flush),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_taken       (out_taken),
      .out_target      (out_target),
      .out_mispredict  (out_mispredict),
      .out_redirect_pc (out_redirect_pc),
      .out_illegal     (out_illegal)
`ifdef BRANCH_RESOLVE_STATS_EN
      ,
      .stat_branches   (stat_branches),
      .stat_mispredicts(stat_mispredicts)
`endif
   );

   always #5 clk = ~clk;

   // Reference: branch semantics from plain integer arithmetic on 64-bit values.
   function automatic exp_t ref_model(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b, input logic [31:0] pc,
                                      input logic [31:0] imm, input logic pred);
      exp_t   r;
      longint ua;
      longint ub;
      longint sa;
      longint sb;
      longint sum;
      longint nxt;
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      sa = (ua >= 64'sd2147483648) ? ua - 64'sd4294967296 : ua;
      sb = (ub >= 64'sd2147483648) ? ub - 64'sd4294967296 : ub;
      r.ill = 1'b0;
      case (f)
         3'd0: r.taken = (ua == ub);
         3'd1: r.taken = (ua != ub);
         3'd4: r.taken = (sa < sb);
         3'd5: r.taken = (sa >= sb);
         3'd6: r.taken = (ua < ub);
         3'd7: r.taken = (ua >= ub);
         default: begin
            r.taken = 1'b0;
            r.ill   = 1'b1;
         end
      endcase
      sum = (longint'({32'b0, pc}) + longint'({32'b0, imm})) % 64'sd4294967296;
      nxt = (longint'({32'b0, pc}) + 64'sd4) % 64'sd4294967296;
      r.target   = sum[31:0];
      r.redirect = r.taken ? sum[31:0] : nxt[31:0];
      r.mis      = (r.taken != pred);
      return r;
   endfunction

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic check_result(input string tag, input exp_t x);
      check_output({tag, ".taken"}, 64'(out_taken), 64'(x.taken));
      check_output({tag, ".target"}, 64'(out_target), 64'(x.target));
      check_output({tag, ".redirect"}, 64'(out_redirect_pc), 64'(x.redirect));
      check_output({tag, ".mispredict"}, 64'(out_mispredict), 64'(x.mis));
      check_output({tag, ".illegal"}, 64'(out_illegal), 64'(x.ill));
   endtask

   task automatic apply_stimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] pc, input logic [31:0] imm, input logic pred);
      in_func       = f;
      in_a          = a;
      in_b          = b;
      in_pc         = pc;
      in_imm        = imm;
      in_pred_taken = pred;
      in_valid      = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0] = '{3'b000, 32'h1234, 32'h1234, 32'h100, 32'h20, 1'b0,
                  '{1'b1, 32'h120, 32'h120, 1'b1, 1'b0}};
      vecs[1] = '{3'b100, 32'hFFFFFFFF, 32'h1, 32'h200, 32'hFFFFFFF0, 1'b1,
                  '{1'b1, 32'h1F0, 32'h1F0, 1'b0, 1'b0}};
      vecs[2] = '{3'b110, 32'hFFFFFFFF, 32'h1, 32'h200, 32'hFFFFFFF0, 1'b1,
                  '{1'b0, 32'h1F0, 32'h204, 1'b1, 1'b0}};
      vecs[3] = '{3'b101, 32'h5, 32'h5, 32'h300, 32'h8, 1'b0,
                  '{1'b1, 32'h308, 32'h308, 1'b1, 1'b0}};
      vecs[4] = '{3'b111, 32'h0, 32'hFFFFFFFF, 32'h400, 32'h40, 1'b0,
                  '{1'b0, 32'h440, 32'h404, 1'b0, 1'b0}};
      vecs[5] = '{3'b001, 32'h7, 32'h7, 32'hFFFFFFFC, 32'h10, 1'b0,
                  '{1'b0, 32'hC, 32'h0, 1'b0, 1'b0}};
      vecs[6] = '{3'b010, 32'h1, 32'h1, 32'h500, 32'h4, 1'b1,
                  '{1'b0, 32'h504, 32'h504, 1'b1, 1'b1}};
      vecs[7] = '{3'b011, 32'h0, 32'h0, 32'h600, 32'hC, 1'b0,
                  '{1'b0, 32'h60C, 32'h604, 1'b0, 1'b1}};
      vecs[8] = '{3'b100, 32'h80000000, 32'h7FFFFFFF, 32'h700, 32'h100, 1'b0,
                  '{1'b1, 32'h800, 32'h800, 1'b1, 1'b0}};
      vecs[9] = '{3'b001, 32'h1, 32'h2, 32'hFFFFFFF0, 32'h20, 1'b1,
                  '{1'b1, 32'h10, 32'h10, 1'b0, 1'b0}};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_output("reset.out_valid", 64'(out_valid), 64'd0);
      check_result("reset", '0);
      check_output("reset.in_ready", 64'(in_ready), 64'd1);
      rst_n = 1'b1;
      tick();

      // Vector table, back-to-back with the consumer always ready
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         apply_stimulus(vecs[i].func, vecs[i].a, vecs[i].b, vecs[i].pc, vecs[i].imm, vecs[i].pred);
         #1;
         check_output($sformatf("vec%0d.in_ready", i), 64'(in_ready), 64'd1);
         tick();
         check_output($sformatf("vec%0d.out_valid", i), 64'(out_valid), 64'd1);
         check_result($sformatf("vec%0d", i), vecs[i].exp);
      end
      in_valid = 1'b0;
      tick();
      check_output("drain.out_valid", 64'(out_valid), 64'd0);

      // Backpressure: first result held, second waits, then both emerge in order
      out_ready = 1'b0;
      apply_stimulus(3'b100, 32'hFFFFFFFF, 32'h1, 32'h1000, 32'h40, 1'b0);
      tick();
      apply_stimulus(3'b111, 32'h0, 32'hFFFFFFFF, 32'h2000, 32'h80, 1'b1);
      e = ref_model(3'b100, 32'hFFFFFFFF, 32'h1, 32'h1000, 32'h40, 1'b0);
      for (int c = 0; c < 3; c++) begin
         #1;
         check_output($sformatf("bp%0d.in_ready", c), 64'(in_ready), 64'd0);
         check_output($sformatf("bp%0d.out_valid", c), 64'(out_valid), 64'd1);
         check_result($sformatf("bp%0d.first", c), e);
         tick();
      end
      out_ready = 1'b1;
      #1;
      check_output("bp.release.in_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      check_output("bp.second.out_valid", 64'(out_valid), 64'd1);
      check_result("bp.second", ref_model(3'b111, 32'h0, 32'hFFFFFFFF, 32'h2000, 32'h80, 1'b1));
      tick();
      check_output("bp.empty.out_valid", 64'(out_valid), 64'd0);

      // Flush with a held result and a new request pending
      out_ready = 1'b0;
      apply_stimulus(3'b000, 32'h9, 32'h9, 32'h3000, 32'h10, 1'b1);
      tick();
      apply_stimulus(3'b001, 32'h1, 32'h2, 32'h4000, 32'h20, 1'b0);
      flush = 1'b1;
      #1;
      check_output("flush.in_ready", 64'(in_ready), 64'd0);
      tick();
      check_output("flush.out_valid", 64'(out_valid), 64'd0);
      flush    = 1'b0;
      in_valid = 1'b0;
      #1;
      check_output("postflush.in_ready", 64'(in_ready), 64'd1);
      tick();
      check_output("postflush.not_captured", 64'(out_valid), 64'd0);

      // Asynchronous reset while a result is pending
      apply_stimulus(3'b000, 32'h5, 32'h5, 32'h5000, 32'h30, 1'b0);
      tick();
      in_valid = 1'b0;
      check_output("rstmid.before", 64'(out_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check_output("rstmid.async.out_valid", 64'(out_valid), 64'd0);
      check_output("rstmid.async.target", 64'(out_target), 64'd0);
      check_output("rstmid.async.taken", 64'(out_taken), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      check_output("rstmid.no_replay", 64'(out_valid), 64'd0);

`ifdef BRANCH_RESOLVE_STATS_EN
      // Ten consumed branches with three mispredicts, one flushed result
      for (int i = 0; i < 10; i++) begin
         apply_stimulus(3'b000, 32'h1, 32'h1, 32'h100, 32'h8, (i < 3) ? 1'b0 : 1'b1);
         tick();
      end
      apply_stimulus(3'b000, 32'h1, 32'h1, 32'h100, 32'h8, 1'b0);
      tick();
      in_valid = 1'b0;
      flush    = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      check_output("stats.branches", 64'(stat_branches), 64'd10);
      check_output("stats.mispredicts", 64'(stat_mispredicts), 64'd3);
      #2 rst_n = 1'b0;
      #1;
      check_output("stats.rst.branches", 64'(stat_branches), 64'd0);
      check_output("stats.rst.mispredicts", 64'(stat_mispredicts), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
`endif

      // Randomized traffic against the reference model
      begin
         logic exp_ready;
         logic [31:0] ra;
         logic [31:0] rb;
         logic [2:0]  rf;
         logic [31:0] rpc;
         logic [31:0] rimm;
         logic        rpred;
         int          m_br;
         int          m_mis;
         m_br  = 0;
         m_mis = 0;
         q.delete();
         for (int n = 0; n < 400; n++) begin
            rf    = 3'($urandom_range(0, 7));
            ra    = $urandom;
            rb    = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            rpc   = $urandom & 32'hFFFFFFFC;
            rimm  = $urandom;
            rpred = 1'($urandom_range(0, 1));
            apply_stimulus(rf, ra, rb, rpc, rimm, rpred);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            #1;
            exp_ready = !flush && ((q.size() == 0) || out_ready);
            check_output($sformatf("rand%0d.in_ready", n), 64'(in_ready), 64'(exp_ready));
            check_output($sformatf("rand%0d.out_valid", n), 64'(out_valid), 64'(q.size() != 0));
            if (q.size() != 0) begin
               check_result($sformatf("rand%0d", n), q[0]);
            end
            if (flush) begin
               q.delete();
            end else begin
               if ((q.size() != 0) && out_ready) begin
                  if (!q[0].ill) begin
                     m_br++;
                     if (q[0].mis) m_mis++;
                  end
                  void'(q.pop_front());
               end
               if (in_valid && exp_ready) begin
                  q.push_back(ref_model(rf, ra, rb, rpc, rimm, rpred));
               end
            end
            tick();
         end
         flush    = 1'b0;
         in_valid = 1'b0;
`ifdef BRANCH_RESOLVE_STATS_EN
         check_output("rand.stat_branches", 64'(stat_branches), 64'(m_br));
         check_output("rand.stat_mispredicts", 64'(stat_mispredicts), 64'(m_mis));
`endif
         if (m_br < 0 || m_mis < 0) $display("[TB] counter underflow");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
